dht22_sensor_emu: RTL and testbench
===================================

# dht22_sensor_emu

Device-side counterpart of the DHT22 host controller: emulates a DHT22 sensor on a single-wire bus. It detects the host start pulse, answers with the sensor response, and serialises a 40-bit frame of humidity, temperature and checksum. Used on-board and in loop-back benches to exercise the host controller without a physical sensor.

## Interface
- CLK_FREQ, 100000000, system clock in Hz; must be an integer multiple of 1 MHz (US = CLK_FREQ/1000000 clocks per µs)
- clk  in  1  system clock
- arstn  in  1  asynchronous active-low reset
- dht22_in  in  1  bus level as seen at the pad (asynchronous)
- dht22_out  out  1  value driven when driving; always 0 while driving, 1 otherwise
- dht22_dir  out  1  pad direction: 1 = input/released, 0 = driving low
- sensor_en  in  1  1 = respond to host starts; 0 = ignore bus
- humidity_in  in  16  humidity word to send
- temperature_in  in  16  temperature word to send
- corrupt_chk  in  1  1 = send inverted checksum (error injection)
- busy  out  1  high whenever state ≠ S_IDLE
- frame_done  out  1  one-cycle pulse at end of a complete transmission

## Operation
- Bus input passes through a 3-flop synchroniser (reset value 1); all decisions use the last stage; falling/rising edges derived from last two stages.
- Reset values: dht22_out=1, dht22_dir=1, busy=0, frame_done=0, state S_IDLE, counter 0, bit index 0.
- dht22_dir = dht22_out at all times (drive only a low; release otherwise).
- States and transitions:
  - S_IDLE: on synchronised falling edge and sensor_en=1 → S_HOST_LOW, counter cleared.
  - S_HOST_LOW: counter runs (saturates). Rising edge with counter ≥ 800·US → S_WAIT, sample humidity_in, temperature_in, corrupt_chk into 40-bit shift register; rising edge earlier → S_IDLE (glitch/short pulse, no response).
  - S_WAIT: released; after 30·US clocks → S_RESP_LOW.
  - S_RESP_LOW: drive low 80·US → S_RESP_HIGH.
  - S_RESP_HIGH: release 80·US → S_BIT_LOW.
  - S_BIT_LOW: drive low 50·US → S_BIT_HIGH.
  - S_BIT_HIGH: release 26·US if current bit 0, 70·US if 1; then shift; if 40 bits sent → S_TAIL_LOW else S_BIT_LOW.
  - S_TAIL_LOW: drive low 50·US → S_IDLE, pulse frame_done.
- Frame order MSB first: humidity[15:0], temperature[15:0], checksum[7:0].
- Checksum = (h[15:8]+h[7:0]+t[15:8]+t[7:0]) mod 256, 8-bit wrap; XOR 8'hFF when sampled corrupt_chk=1.
- sensor_en deasserted mid-frame has no effect; checked only in S_IDLE.
- Bus activity during S_WAIT…S_TAIL_LOW is ignored (no collision detect).
- Inputs changing after sampling do not affect the frame in flight.

## Timing
- Every drive/release phase lasts exactly its stated clock count; counter reloads on each transition, no dead cycles between phases.
- Host-release to first low drive: 3 sync cycles + 30·US clocks (±1).
- Frame data phase: 40·50·US + Σ(26 or 70)·US clocks.
- frame_done asserts in the cycle S_TAIL_LOW → S_IDLE and dht22_dir returns to 1 in that same cycle.
- Host low exactly 800·US counts as valid.
- arstn low at any point: immediate release of bus (dir=1), state S_IDLE, frame discarded, no frame_done.
- Counter width $clog2(800·US)+1, saturating in S_HOST_LOW; holding low indefinitely is legal.

## Structure
- Shared package dht22_pkg: state enum type, microsecond constants (800, 30, 80, 50, 26, 70), frame width 40; module converts to clocks via US localparam.
- Sub-module dht22_sync_edge: 3-flop synchroniser plus rise/fall strobes, reset to 1; reusable by the host controller.

## Test plan
Use CLK_FREQ=1000000 (US=1) for all scenarios.
- Host low 1000 clk, release; hum=16'h028C, temp=16'h0115, corrupt_chk=0 → response 80 low/80 high, 40 bits decoded 028C_0115_A4, frame_done once, busy falls same cycle.
- Host low 500 clk, release → no drive (dir stays 1), back to idle, busy low within 4 clk of release.
- Same as 1 with corrupt_chk=1 → checksum byte 8'h5B.
- hum=16'hFFFF, temp=16'hFFFF → checksum wraps to 8'hFC; all bit-high phases 70 clk.
- sensor_en=0, valid 1000-clk start → bus never driven, busy stays 0.
- arstn pulsed low during bit 20 → dir=1 immediately, no frame_done; subsequent valid start produces a full correct frame.

Source files
------------

// File: rtl/dht22_pkg.sv
// dht22_pkg: shared state encoding, phase timings in microseconds and checksum helper
package dht22_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_HOST_LOW  = 3'd1;
    localparam state_t S_WAIT      = 3'd2;
    localparam state_t S_RESP_LOW  = 3'd3;
    localparam state_t S_RESP_HIGH = 3'd4;
    localparam state_t S_BIT_LOW   = 3'd5;
    localparam state_t S_BIT_HIGH  = 3'd6;
    localparam state_t S_TAIL_LOW  = 3'd7;

    localparam int HOST_US    = 800;
    localparam int WAIT_US    = 30;
    localparam int RESP_US    = 80;
    localparam int BIT_LOW_US = 50;
    localparam int BIT0_US    = 26;
    localparam int BIT1_US    = 70;
    localparam int FRAME_W    = 40;

    function automatic logic [7:0] checksum(input logic [15:0] h, input logic [15:0] t);
        return h[15:8] + h[7:0] + t[15:8] + t[7:0];
    endfunction

endpackage

// File: rtl/dht22_sync_edge.sv
// dht22_sync_edge: 3-flop bus synchroniser (idles high) with rise/fall strobes
module dht22_sync_edge (
    input  logic clk,
    input  logic arstn,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [2:0] s;

    // shift the pad level through three flops; reset to the released-bus level
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) s <= 3'b111;
        else        s <= {s[1:0], d};
    end

    assign rise = s[1] & ~s[2];
    assign fall = ~s[1] & s[2];

endmodule

// File: rtl/dht22_sensor_emu.sv
// dht22_sensor_emu: single-wire DHT22 sensor emulator answering host start pulses with a 40-bit frame
module dht22_sensor_emu
    import dht22_pkg::*;
#(
    parameter int CLK_FREQ = 100000000
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic        dht22_in,
    output logic        dht22_out,
    output logic        dht22_dir,
    input  logic        sensor_en,
    input  logic [15:0] humidity_in,
    input  logic [15:0] temperature_in,
    input  logic        corrupt_chk,
    output logic        busy,
    output logic        frame_done
);

    localparam int US = CLK_FREQ / 1000000;
    localparam int CW = $clog2(HOST_US * US) + 1;

    // the fall-strobe cycle is already a low clock, so an exact 800 us pulse ends at HOST_US*US-1
    localparam logic [CW-1:0] HOST_MIN  = CW'(HOST_US * US - 1);
    localparam logic [CW-1:0] WAIT_C    = CW'(WAIT_US * US);
    localparam logic [CW-1:0] RESP_C    = CW'(RESP_US * US);
    localparam logic [CW-1:0] BIT_LOW_C = CW'(BIT_LOW_US * US);
    localparam logic [CW-1:0] BIT0_C    = CW'(BIT0_US * US);
    localparam logic [CW-1:0] BIT1_C    = CW'(BIT1_US * US);
    localparam logic [5:0]    LAST_BIT  = 6'(FRAME_W - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      lim;
    logic [FRAME_W-1:0] sh;
    logic [5:0]         idx;
    logic               rise;
    logic               fall;
    logic               ph_end;

    dht22_sync_edge u_sync (
        .clk  (clk),
        .arstn(arstn),
        .d    (dht22_in),
        .rise (rise),
        .fall (fall)
    );

    // length of the current timed phase in clocks
    always_comb begin
        lim = (state == S_WAIT) ? WAIT_C :
              (state == S_RESP_LOW || state == S_RESP_HIGH) ? RESP_C :
              (state == S_BIT_HIGH) ? (sh[FRAME_W-1] ? BIT1_C : BIT0_C) : BIT_LOW_C;
    end

    assign ph_end = (cnt == lim - 1'b1);

    // protocol sequencer: host start detection, response, bit serialisation and tail
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sh         <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (fall && sensor_en) state <= S_HOST_LOW;
                end
                S_HOST_LOW: begin
                    if (rise) begin
                        cnt <= '0;
                        idx <= '0;
                        if (cnt >= HOST_MIN) begin
                            state <= S_WAIT;
                            sh    <= {humidity_in, temperature_in,
                                      checksum(humidity_in, temperature_in) ^ {8{corrupt_chk}}};
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (cnt != {CW{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (!ph_end) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        case (state)
                            S_WAIT:      state <= S_RESP_LOW;
                            S_RESP_LOW:  state <= S_RESP_HIGH;
                            S_RESP_HIGH: state <= S_BIT_LOW;
                            S_BIT_LOW:   state <= S_BIT_HIGH;
                            S_BIT_HIGH: begin
                                sh    <= {sh[FRAME_W-2:0], 1'b0};
                                idx   <= idx + 1'b1;
                                state <= (idx == LAST_BIT) ? S_TAIL_LOW : S_BIT_LOW;
                            end
                            default: begin
                                state      <= S_IDLE;
                                frame_done <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign dht22_out = !(state == S_RESP_LOW || state == S_BIT_LOW || state == S_TAIL_LOW);
    assign dht22_dir = dht22_out;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_dht22_sensor_emu.sv
// tb_dht22_sensor_emu: directed scenarios decoding the emulated sensor's bus activity
module tb_dht22_sensor_emu;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        host_low = 1'b0;
    logic        sensor_en = 1'b1;
    logic        corrupt_chk = 1'b0;
    logic [15:0] hum = 16'h0;
    logic [15:0] temp = 16'h0;
    logic        dht22_in;
    logic        dht22_out;
    logic        dht22_dir;
    logic        busy;
    logic        frame_done;

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;
    int drv_cnt = 0;
    int busy_cnt = 0;
    logic busy_at_fd = 1'b1;

    always #5 clk = ~clk;

    // open-drain bus with pull-up: low if either side drives low
    assign dht22_in = host_low ? 1'b0 : (dht22_dir ? 1'b1 : dht22_out);

    dht22_sensor_emu #(.CLK_FREQ(1000000)) dut (
        .clk           (clk),
        .arstn         (arstn),
        .dht22_in      (dht22_in),
        .dht22_out     (dht22_out),
        .dht22_dir     (dht22_dir),
        .sensor_en     (sensor_en),
        .humidity_in   (hum),
        .temperature_in(temp),
        .corrupt_chk   (corrupt_chk),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    // activity monitors sampled away from the active edge
    always @(negedge clk) begin
        if (frame_done) begin
            fd_cnt     <= fd_cnt + 1;
            busy_at_fd <= busy;
        end
        if (!dht22_dir) drv_cnt <= drv_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic host_start(input int n);
        @(negedge clk);
        host_low = 1'b1;
        repeat (n) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (dht22_dir === lvl && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic capture(output int wait_n, output int rlo, output int rhi,
                           output logic [39:0] bits, output int bad_lo,
                           output int bad_hi, output int n_long, output int tail);
        int lo;
        int hi;
        wait_n = 0; rlo = 0; rhi = 0; bits = '0; bad_lo = 0; bad_hi = 0; n_long = 0; tail = 0;
        while (dht22_dir !== 1'b0 && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        if (wait_n >= 100) return;
        run_len(1'b0, rlo);
        run_len(1'b1, rhi);
        for (int i = 0; i < 40; i++) begin
            run_len(1'b0, lo);
            run_len(1'b1, hi);
            if (lo != 50) bad_lo++;
            if (hi != 26 && hi != 70) bad_hi++;
            if (hi == 70) n_long++;
            bits = {bits[38:0], hi > 40};
        end
        run_len(1'b0, tail);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (dht22_out !== 1'b1) begin bad++; $display("FAIL reset_out got=%b exp=1", dht22_out); end
        total++; if (dht22_dir !== 1'b1) begin bad++; $display("FAIL reset_dir got=%b exp=1", dht22_dir); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        arstn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // full valid transaction; inputs are scrambled after sampling to prove they are latched
    task automatic test_frame(input logic [15:0] h, input logic [15:0] t, input logic c,
                              input logic [39:0] exp_bits, input int exp_long);
        int wait_n, rlo, rhi, bad_lo, bad_hi, n_long, tail, fd0;
        logic [39:0] bits;
        logic fd_at_end;
        hum = h; temp = t; corrupt_chk = c;
        fd0 = fd_cnt;
        host_start(1000);
        repeat (5) @(negedge clk);
        hum = ~h; temp = ~t; corrupt_chk = ~c;
        capture(wait_n, rlo, rhi, bits, bad_lo, bad_hi, n_long, tail);
        fd_at_end = frame_done;
        total++; if (wait_n + 5 < 32 || wait_n + 5 > 34) begin bad++; $display("FAIL frame_wait got=%0d exp=33+-1", wait_n + 5); end
        total++; if (rlo !== 80) begin bad++; $display("FAIL resp_low got=%0d exp=80", rlo); end
        total++; if (rhi !== 80) begin bad++; $display("FAIL resp_high got=%0d exp=80", rhi); end
        total++; if (bits !== exp_bits) begin bad++; $display("FAIL frame_bits got=%h exp=%h", bits, exp_bits); end
        total++; if (bad_lo !== 0) begin bad++; $display("FAIL bit_low_len got=%0d_bad exp=0_bad", bad_lo); end
        total++; if (bad_hi !== 0) begin bad++; $display("FAIL bit_high_len got=%0d_bad exp=0_bad", bad_hi); end
        total++; if (n_long !== exp_long) begin bad++; $display("FAIL long_bits got=%0d exp=%0d", n_long, exp_long); end
        total++; if (tail !== 50) begin bad++; $display("FAIL tail_low got=%0d exp=50", tail); end
        total++; if (fd_at_end !== 1'b1) begin bad++; $display("FAIL frame_done_at_release got=%b exp=1", fd_at_end); end
        repeat (5) @(negedge clk);
        total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL frame_done_count got=%0d exp=1", fd_cnt - fd0); end
        total++; if (busy_at_fd !== 1'b0) begin bad++; $display("FAIL busy_at_done got=%b exp=0", busy_at_fd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_short_pulse;
        int fd0, drv0;
        fd0 = fd_cnt; drv0 = drv_cnt;
        host_start(500);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL short_busy_during got=%b exp=1", busy); end
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL short_busy_release got=%b exp=0", busy); end
        repeat (60) @(negedge clk);
        total++; if (drv_cnt - drv0 !== 0) begin bad++; $display("FAIL short_driven got=%0d exp=0", drv_cnt - drv0); end
        total++; if (fd_cnt - fd0 !== 0) begin bad++; $display("FAIL short_frame_done got=%0d exp=0", fd_cnt - fd0); end
    endtask

    task automatic test_disabled;
        int drv0, b0;
        sensor_en = 1'b0;
        drv0 = drv_cnt; b0 = busy_cnt;
        host_start(1000);
        repeat (80) @(negedge clk);
        total++; if (drv_cnt - drv0 !== 0) begin bad++; $display("FAIL disabled_driven got=%0d exp=0", drv_cnt - drv0); end
        total++; if (busy_cnt - b0 !== 0) begin bad++; $display("FAIL disabled_busy got=%0d exp=0", busy_cnt - b0); end
        sensor_en = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        int n, fd0, drv0;
        hum = 16'hABCD; temp = 16'h0123; corrupt_chk = 1'b0;
        fd0 = fd_cnt;
        host_start(1000);
        n = 0;
        while (dht22_dir !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        total++; if (n >= 100) begin bad++; $display("FAIL midreset_start got=timeout exp=drive"); end
        run_len(1'b0, n);
        run_len(1'b1, n);
        for (int i = 0; i < 20; i++) begin
            run_len(1'b0, n);
            run_len(1'b1, n);
        end
        repeat (10) @(negedge clk);
        total++; if (dht22_dir !== 1'b0) begin bad++; $display("FAIL midreset_in_bit20 got=%b exp=0", dht22_dir); end
        #2 arstn = 1'b0;
        #1;
        total++; if (dht22_dir !== 1'b1) begin bad++; $display("FAIL midreset_dir got=%b exp=1", dht22_dir); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        @(negedge clk);
        arstn = 1'b1;
        drv0 = drv_cnt;
        repeat (3000) @(negedge clk);
        total++; if (fd_cnt - fd0 !== 0) begin bad++; $display("FAIL midreset_frame_done got=%0d exp=0", fd_cnt - fd0); end
        total++; if (drv_cnt - drv0 !== 0) begin bad++; $display("FAIL midreset_driven got=%0d exp=0", drv_cnt - drv0); end
    endtask

    initial begin
        test_reset();
        test_frame(16'h028C, 16'h0115, 1'b0, 40'h028C_0115_A4, 11);
        test_short_pulse();
        test_frame(16'h028C, 16'h0115, 1'b1, 40'h028C_0115_5B, 13);
        test_frame(16'hFFFF, 16'hFFFF, 1'b0, 40'hFFFF_FFFF_FC, 38);
        test_disabled();
        test_reset_mid_frame();
        test_frame(16'h1234, 16'h5678, 1'b0, 40'h1234_5678_14, 15);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
